// File: rtl/seq_restoring_divider_pkg.sv
// seq_restoring_divider_pkg: shared state encoding and default operand width for the divider
package seq_restoring_divider_pkg;
  localparam int DEF_WIDTH = 4;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/seq_restoring_divider_if.sv
// seq_restoring_divider_if: request/result bundle between a requester and the divider
interface seq_restoring_divider_if
  import seq_restoring_divider_pkg::*;
#(parameter int WIDTH = DEF_WIDTH);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );
  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_restoring_divider_trial_sub.sv
// div_trial_sub: ripple a - b over WIDTH+1 bits as a + ~b + 1; carry-out high means no borrow
module div_trial_sub #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH:0]   b,
  output logic [WIDTH-1:0] diff,
  output logic             no_borrow
);
  logic [WIDTH+1:0] c;
  logic [WIDTH:0]   nb;
  assign c[0] = 1'b1;
  assign nb   = ~b;
  // Top difference bit is only consumed when there is no borrow, where it is always zero,
  // so only the carry is produced for that position.
  genvar i;
  for (i = 0; i <= WIDTH; i++) begin : g_fa
    assign c[i+1] = (a[i] & nb[i]) | (c[i] & (a[i] ^ nb[i]));
    if (i < WIDTH) begin : g_s
      assign diff[i] = a[i] ^ nb[i] ^ c[i];
    end
  end
  assign no_borrow = c[WIDTH+1];
endmodule

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: multi-cycle unsigned restoring divider, one quotient bit per clock
module seq_restoring_divider
  import seq_restoring_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  seq_restoring_divider_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] quo_sr_q, quo_sr_d;
  logic [WIDTH-1:0] rem_sr_q, rem_sr_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic [CW-1:0]    count_q, count_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             no_borrow;
  // Partial remainder stays below the divisor between steps, so its extra top bit is always
  // zero and only WIDTH bits are kept; the shift supplies the (WIDTH+1)-bit trial operand.
  assign shifted = {rem_sr_q, quo_sr_q[WIDTH-1]};
  div_trial_sub #(.WIDTH(WIDTH)) u_sub (
    .a        (shifted),
    .b        ({1'b0, dvs_q}),
    .diff     (diff),
    .no_borrow(no_borrow)
  );
  // Next-state, datapath step and result capture; results move only on completion
  always_comb begin
    state_d     = state_q;
    quo_sr_d    = quo_sr_q;
    rem_sr_d    = rem_sr_q;
    dvs_d       = dvs_q;
    count_d     = count_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    case (state_q)
      IDLE: if (bus.start) begin
        if (bus.divisor != '0) begin
          state_d  = RUN;
          quo_sr_d = bus.dividend;
          rem_sr_d = '0;
          dvs_d    = bus.divisor;
          count_d  = CW'(WIDTH);
        end else begin
          state_d     = DONE;
          quotient_d  = '1;
          remainder_d = bus.dividend;
          dbz_d       = 1'b1;
        end
      end
      RUN: begin
        quo_sr_d = {quo_sr_q[WIDTH-2:0], no_borrow};
        rem_sr_d = no_borrow ? diff : shifted[WIDTH-1:0];
        count_d  = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_d     = DONE;
          quotient_d  = quo_sr_d;
          remainder_d = rem_sr_d;
          dbz_d       = 1'b0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      quo_sr_q    <= '0;
      rem_sr_q    <= '0;
      dvs_q       <= '0;
      count_q     <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      quo_sr_q    <= quo_sr_d;
      rem_sr_q    <= rem_sr_d;
      dvs_q       <= dvs_d;
      count_q     <= count_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end
  assign bus.busy        = state_q != IDLE;
  assign bus.done        = state_q == DONE;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider: vector table, corner sequences, random ops and a full operand sweep
module tb_seq_restoring_divider;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  seq_restoring_divider_if #(.WIDTH(4)) bus ();
  seq_restoring_divider #(.WIDTH(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0] a, b, q, r;
    logic       z;
    int         lat;
  } vec_t;
  typedef struct {
    logic [3:0] q, r;
    logic       z;
    int         lat;
    int         acc;
  } exp_t;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // Issue one op from an idle negedge; checks latency, results, held outputs and single done
  task automatic do_op(input string nm, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] eq, input logic [3:0] er, input logic ez, input int elat);
    int         lat;
    logic       held;
    logic [3:0] hq, hr;
    logic       hz;
    hq = bus.quotient; hr = bus.remainder; hz = bus.div_by_zero; held = 1'b1;
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
    @(negedge clk);
    bus.start = 1'b0; bus.dividend = 4'($urandom); bus.divisor = 4'($urandom);
    lat = 1;
    while (!bus.done && lat < 20) begin
      if (!bus.busy || bus.quotient !== hq || bus.remainder !== hr || bus.div_by_zero !== hz) held = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk({nm, " latency"}, lat, elat);
    chk({nm, " quotient"}, bus.quotient, eq);
    chk({nm, " remainder"}, bus.remainder, er);
    chk({nm, " div_by_zero"}, bus.div_by_zero, ez);
    chk({nm, " busy at done"}, bus.busy, 1);
    chk({nm, " held while running"}, held, 1);
    @(negedge clk);
    chk({nm, " done single pulse"}, bus.done, 0);
    chk({nm, " idle after"}, bus.busy, 0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    vec_t tbl[10];
    exp_t sq[$];
    exp_t e;
    int   dones, dcyc, cyc, idx, got;
    logic saw_done;
    logic [3:0] a, b;
    tbl[0] = '{4'd13, 4'd3,  4'd4,  4'd1, 1'b0, 5};
    tbl[1] = '{4'd15, 4'd1,  4'd15, 4'd0, 1'b0, 5};
    tbl[2] = '{4'd7,  4'd9,  4'd0,  4'd7, 1'b0, 5};
    tbl[3] = '{4'd9,  4'd0,  4'hF,  4'd9, 1'b1, 1};
    tbl[4] = '{4'd8,  4'd2,  4'd4,  4'd0, 1'b0, 5};
    tbl[5] = '{4'd0,  4'd7,  4'd0,  4'd0, 1'b0, 5};
    tbl[6] = '{4'd15, 4'd15, 4'd1,  4'd0, 1'b0, 5};
    tbl[7] = '{4'd1,  4'd15, 4'd0,  4'd1, 1'b0, 5};
    tbl[8] = '{4'd0,  4'd0,  4'hF,  4'd0, 1'b1, 1};
    tbl[9] = '{4'd14, 4'd5,  4'd2,  4'd4, 1'b0, 5};
    rst_n = 1'b0; bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("reset busy", bus.busy, 0);
    chk("reset done", bus.done, 0);
    chk("reset quotient", bus.quotient, 0);
    chk("reset remainder", bus.remainder, 0);
    chk("reset div_by_zero", bus.div_by_zero, 0);
    for (int i = 0; i < 10; i++)
      do_op($sformatf("vec%0d %0d/%0d", i, tbl[i].a, tbl[i].b), tbl[i].a, tbl[i].b,
            tbl[i].q, tbl[i].r, tbl[i].z, tbl[i].lat);
    // Requests raised while busy (cycles 2 and 5) must be dropped
    bus.start = 1'b1; bus.dividend = 4'd12; bus.divisor = 4'd5;
    dones = 0; dcyc = -1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (bus.done) begin dones++; dcyc = c; end
      bus.start = (c == 2 || c == 5); bus.dividend = 4'd3; bus.divisor = 4'd1;
    end
    chk("ignore done count", dones, 1);
    chk("ignore done cycle", dcyc, 5);
    chk("ignore quotient", bus.quotient, 2);
    chk("ignore remainder", bus.remainder, 2);
    chk("ignore idle", bus.busy, 0);
    // Reset in cycle 3 of a 14/3 op aborts it with no done pulse
    bus.start = 1'b1; bus.dividend = 4'd14; bus.divisor = 4'd3;
    @(negedge clk); bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort busy", bus.busy, 0);
    chk("abort done", bus.done, 0);
    chk("abort quotient", bus.quotient, 0);
    chk("abort remainder", bus.remainder, 0);
    chk("abort div_by_zero", bus.div_by_zero, 0);
    saw_done = 1'b0;
    repeat (3) begin @(negedge clk); if (bus.done) saw_done = 1'b1; end
    rst_n = 1'b1;
    repeat (3) begin @(negedge clk); if (bus.done || bus.busy) saw_done = 1'b1; end
    chk("abort no done", saw_done, 0);
    do_op("after abort 14/3", 4'd14, 4'd3, 4'd4, 4'd2, 1'b0, 5);
    // Random operands against plain-arithmetic reference
    for (int i = 0; i < 40; i++) begin
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      do_op($sformatf("rand %0d/%0d", a, b), a, b,
            (b == 0) ? 4'hF : 4'(int'(a) / int'(b)), (b == 0) ? a : 4'(int'(a) % int'(b)),
            b == 0, (b == 0) ? 1 : 5);
    end
    // All 256 pairs with start held high; each accepted on the first idle cycle
    cyc = 0; idx = 0; got = 0;
    while (got < 256 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (bus.done) begin
        if (sq.size() == 0) chk("sweep spurious done", 1, 0);
        else begin
          e = sq.pop_front();
          chk($sformatf("sweep%0d quotient", got), bus.quotient, e.q);
          chk($sformatf("sweep%0d remainder", got), bus.remainder, e.r);
          chk($sformatf("sweep%0d div_by_zero", got), bus.div_by_zero, e.z);
          chk($sformatf("sweep%0d latency", got), cyc - e.acc, e.lat);
        end
        got++;
      end
      if (idx == 256 && bus.busy) bus.start = 1'b0;
      if (!bus.busy && idx < 256) begin
        a = 4'(idx >> 4); b = 4'(idx);
        bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
        sq.push_back('{(b == 0) ? 4'hF : 4'(int'(a) / int'(b)),
                       (b == 0) ? a : 4'(int'(a) % int'(b)),
                       b == 0, (b == 0) ? 1 : 5, cyc});
        idx++;
      end
    end
    bus.start = 1'b0;
    chk("sweep result count", got, 256);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
